// File: rtl/matrix_inv3_seq_pkg.sv
// -----------------------------------------------------------------------------
// matinv_pkg
//   Shared definitions for the sequential 3x3 matrix inverter.
//   - FSM state encoding (IDLE, COF, DET, DIV, DONE) as plain 3-bit constants
//   - width helpers: cofactor width, determinant width, divider iteration count
//   - saturate(): clamp a wide signed value into an out_w-bit signed range
// -----------------------------------------------------------------------------
package matinv_pkg;

    // State encoding; the live state is exported on the interface as dbg_state.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_COF  = 3'd1;
    localparam state_t ST_DET  = 3'd2;
    localparam state_t ST_DIV  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Width of the value handed to saturate(); wide enough for any quotient
    // produced with practical DATA_W/FRAC_W settings.
    localparam int SAT_W = 64;

    // A 2x2 minor of DATA_W-bit operands: difference of two 2*DATA_W products.
    function automatic int cof_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Three DATA_W x CW products summed.
    function automatic int det_width(input int data_w);
        return 3 * data_w + 2;
    endfunction

    // One restoring step per numerator bit; the numerator is adj << frac_w.
    function automatic int div_iters(input int data_w, input int frac_w);
        return cof_width(data_w) + frac_w;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] x,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/matrix_inv3_seq_if.sv
// -----------------------------------------------------------------------------
// matrix_inv3_seq_if
//   Bundles the input and output handshakes of matrix_inv3_seq.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer holds valid and its
//   payload stable until that edge; ready may change freely and has no effect
//   while valid is low. Here in_ready is high exactly in IDLE and out_valid is
//   high exactly in DONE, so the two channels never overlap.
//
//   Signals
//     in_valid  : matrix presented on a
//     in_ready  : block idle, will accept a
//     a         : 9 x DATA_W row-major signed elements, a11 at [DATA_W-1:0]
//     out_valid : result available on b/det/singular
//     out_ready : consumer accepts result
//     b         : 9 x OUT_W row-major signed fixed-point inverse
//     det       : signed determinant
//     singular  : det == 0, b is all zero
//     dbg_state : current FSM state (matinv_pkg::ST_*)
//
//   Modports: slave = the inverter, master = whoever feeds/drains it.
// -----------------------------------------------------------------------------
interface matrix_inv3_seq_if
    import matinv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
);
    localparam int DW = det_width(DATA_W);

    logic                   in_valid;
    logic                   in_ready;
    logic [9*DATA_W-1:0]    a;
    logic                   out_valid;
    logic                   out_ready;
    logic [9*OUT_W-1:0]     b;
    logic [DW-1:0]          det;
    logic                   singular;
    logic [2:0]             dbg_state;

    modport slave (
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output b,
        output det,
        output singular,
        output dbg_state
    );

    modport master (
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  b,
        input  det,
        input  singular,
        input  dbg_state
    );

endinterface

// File: rtl/matrix_inv3_seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Signed restoring divider, one quotient bit per clock, NUM_W iterations.
//   Works on magnitudes and applies the sign to the final quotient, so the
//   result truncates toward zero.
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : load num/den and begin (ignored while busy)
//     num        : signed numerator, NUM_W bits
//     den        : signed denominator, DEN_W bits, must be non-zero
//     busy       : iterations in progress
//     done       : one-cycle pulse, quo valid from this cycle on
//     quo        : registered signed quotient, NUM_W+1 bits (holds |num|
//                  for the most negative numerator divided by +/-1)
//
//   Timing: start sampled on edge 0, done/quo visible after edge NUM_W.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int NUM_W = 25,
    parameter int DEN_W = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [NUM_W-1:0] num,
    input  logic signed [DEN_W-1:0] den,
    output logic                    busy,
    output logic                    done,
    output logic signed [NUM_W:0]   quo
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    // q_r starts as |num| and shifts left; quotient bits enter at the bottom.
    logic [NUM_W-1:0] q_r;
    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic             neg_r;
    logic [CNT_W-1:0] cnt_r;

    logic [NUM_W-1:0] num_mag;
    logic [DEN_W-1:0] den_mag;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W:0]   rem_trial;
    logic             fits;
    logic [DEN_W-1:0] rem_nx;
    logic [NUM_W-1:0] q_nx;

    always_comb begin
        num_mag   = num[NUM_W-1] ? $unsigned(-num) : $unsigned(num);
        den_mag   = den[DEN_W-1] ? $unsigned(-den) : $unsigned(den);
        rem_sh    = {rem_r, q_r[NUM_W-1]};
        rem_trial = rem_sh - {1'b0, den_r};
        // rem_sh < 2*den always, so the top bit of the difference is a
        // clean borrow flag.
        fits      = ~rem_trial[DEN_W];
        rem_nx    = fits ? rem_trial[DEN_W-1:0] : rem_sh[DEN_W-1:0];
        q_nx      = {q_r[NUM_W-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            rem_r <= '0;
            den_r <= '0;
            neg_r <= 1'b0;
            cnt_r <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                q_r   <= num_mag;
                rem_r <= '0;
                den_r <= den_mag;
                neg_r <= num[NUM_W-1] ^ den[DEN_W-1];
                cnt_r <= CNT_W'(NUM_W);
                busy  <= 1'b1;
            end else if (busy) begin
                q_r   <= q_nx;
                rem_r <= rem_nx;
                cnt_r <= cnt_r - 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    quo  <= neg_r ? -$signed({1'b0, q_nx}) : $signed({1'b0, q_nx});
                end
            end
        end
    end

endmodule

// File: rtl/matrix_inv3_seq.sv
// -----------------------------------------------------------------------------
// matrix_inv3_seq
//   Sequential 3x3 signed matrix inverter, b = adj(a) / det(a) in fixed point
//   Q(OUT_W-FRAC_W).FRAC_W, saturated, with a singular flag.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, aborts any transaction
//     bus    : matrix_inv3_seq_if.slave (in_valid/in_ready/a,
//              out_valid/out_ready/b/det/singular, dbg_state)
//
//   Flow: IDLE -> COF (9 cycles, one adjugate element each) -> DET (1 cycle)
//         -> DIV (9 divisions of Q+1 cycles, plus one cycle to store the last)
//         -> DONE (held until out_ready). A zero determinant skips DIV.
//   Accept-to-out_valid: 245 cycles at default parameters, 10 when singular.
// -----------------------------------------------------------------------------
module matrix_inv3_seq
    import matinv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_inv3_seq_if.slave   bus
);
    localparam int CW = cof_width(DATA_W);
    localparam int DW = det_width(DATA_W);
    localparam int Q  = div_iters(DATA_W, FRAC_W);

    state_t                    state_r;
    logic [3:0]                idx_r;
    logic                      div_first_r;
    logic signed [DATA_W-1:0]  a_r   [9];
    logic signed [CW-1:0]      adj_r [9];
    logic signed [OUT_W-1:0]   b_r   [9];
    logic signed [DW-1:0]      det_r;
    logic                      sing_r;

    // Next index modulo 3.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Row-major element index of (row, col).
    function automatic logic [3:0] eidx(input logic [1:0] row, input logic [1:0] col);
        return 4'(row) * 4'd3 + 4'(col);
    endfunction

    // ---------------------------------------------------------------------
    // Cofactor mux / multiplier pair.
    // adj[r][c] = C[c][r]. With cyclic neighbours r1=r+1, r2=r+2, c1=c+1,
    // c2=c+2 (mod 3) the sign of the cofactor falls out of the ordering:
    //   adj[r][c] = a[c1][r1]*a[c2][r2] - a[c1][r2]*a[c2][r1]
    // ---------------------------------------------------------------------
    logic [1:0]                r_sel, c_sel, r1, r2, c1, c2;
    logic signed [DATA_W-1:0]  op_p, op_q, op_s, op_t;
    logic signed [2*DATA_W-1:0] prod_pq, prod_st;
    logic signed [CW-1:0]      cof;

    always_comb begin
        r_sel = 2'd0;
        c_sel = 2'd0;
        case (idx_r)
            4'd0: begin r_sel = 2'd0; c_sel = 2'd0; end
            4'd1: begin r_sel = 2'd0; c_sel = 2'd1; end
            4'd2: begin r_sel = 2'd0; c_sel = 2'd2; end
            4'd3: begin r_sel = 2'd1; c_sel = 2'd0; end
            4'd4: begin r_sel = 2'd1; c_sel = 2'd1; end
            4'd5: begin r_sel = 2'd1; c_sel = 2'd2; end
            4'd6: begin r_sel = 2'd2; c_sel = 2'd0; end
            4'd7: begin r_sel = 2'd2; c_sel = 2'd1; end
            4'd8: begin r_sel = 2'd2; c_sel = 2'd2; end
            default: begin r_sel = 2'd0; c_sel = 2'd0; end
        endcase
        r1      = inc3(r_sel);
        r2      = inc3(r1);
        c1      = inc3(c_sel);
        c2      = inc3(c1);
        op_p    = a_r[eidx(c1, r1)];
        op_q    = a_r[eidx(c2, r2)];
        op_s    = a_r[eidx(c1, r2)];
        op_t    = a_r[eidx(c2, r1)];
        prod_pq = op_p * op_q;
        prod_st = op_s * op_t;
        cof     = CW'(prod_pq) - CW'(prod_st);
    end

    // ---------------------------------------------------------------------
    // Determinant MAC: expansion along the first row of a, which is the first
    // column of adj (adj11, adj21, adj31 at indices 0, 3, 6).
    // ---------------------------------------------------------------------
    logic signed [DW-1:0] det_acc;

    always_comb begin
        det_acc = DW'(a_r[0]) * DW'(adj_r[0])
                + DW'(a_r[1]) * DW'(adj_r[3])
                + DW'(a_r[2]) * DW'(adj_r[6]);
    end

    // ---------------------------------------------------------------------
    // Shared divider. The store of element k and the start of element k+1
    // happen in the same cycle, so the numerator mux looks one index ahead
    // whenever it is not the very first division.
    // ---------------------------------------------------------------------
    logic [3:0]            div_sel;
    logic signed [Q-1:0]   div_num;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic signed [Q:0]     div_quo;

    always_comb begin
        div_sel   = (div_first_r || idx_r == 4'd8) ? idx_r : idx_r + 4'd1;
        div_num   = {adj_r[div_sel], {FRAC_W{1'b0}}};
        div_start = (state_r == ST_DIV) && !div_busy &&
                    (div_first_r || (div_done && idx_r != 4'd8));
    end

    seq_divider #(
        .NUM_W (Q),
        .DEN_W (DW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (det_r),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    // ---------------------------------------------------------------------
    // FSM and result register file
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            div_first_r <= 1'b0;
            det_r       <= '0;
            sing_r      <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                a_r[k]   <= '0;
                adj_r[k] <= '0;
                b_r[k]   <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < 9; k++) begin
                            a_r[k] <= bus.a[k*DATA_W +: DATA_W];
                        end
                        idx_r   <= '0;
                        state_r <= ST_COF;
                    end
                end

                ST_COF: begin
                    adj_r[idx_r] <= cof;
                    if (idx_r == 4'd8) begin
                        state_r <= ST_DET;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end

                ST_DET: begin
                    det_r <= det_acc;
                    idx_r <= '0;
                    if (det_acc == '0) begin
                        sing_r <= 1'b1;
                        for (int k = 0; k < 9; k++) begin
                            b_r[k] <= '0;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        sing_r      <= 1'b0;
                        div_first_r <= 1'b1;
                        state_r     <= ST_DIV;
                    end
                end

                ST_DIV: begin
                    div_first_r <= 1'b0;
                    if (div_done) begin
                        b_r[idx_r] <= OUT_W'(saturate(SAT_W'(div_quo), OUT_W));
                        if (idx_r == 4'd8) begin
                            state_r <= ST_DONE;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end

                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.det       = det_r;
    assign bus.singular  = sing_r;
    assign bus.dbg_state = state_r;

    for (genvar g = 0; g < 9; g++) begin : g_pack_b
        assign bus.b[g*OUT_W +: OUT_W] = b_r[g];
    end

endmodule

// File: tb/tb_matrix_inv3_seq.sv
module tb_matrix_inv3_seq;
  localparam int DATA_W  = 8;
  localparam int FRAC_W  = 8;
  localparam int OUT_W   = 16;
  localparam int OUT_W_S = 12;
  localparam int LAT_FULL = 245;
  localparam int LAT_SING = 10;
  localparam int BUDGET   = 1000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_inv3_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W))   bus0();
  matrix_inv3_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W_S)) bus1();

  matrix_inv3_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  matrix_inv3_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W_S)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] sxd(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

  function automatic logic [71:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [71:0] v;
    int e[9];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(e[k]);
    return v;
  endfunction

  task automatic push9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    int e[9];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    for (int k = 0; k < 9; k++) exp_q.push_back(32'(e[k]));
  endtask

  task automatic check_b0(input string tag);
    logic [31:0] exp;
    for (int k = 0; k < 9; k++) begin
      exp = exp_q.pop_front();
      chk($sformatf("%s_b%0d", tag, k), sx16(bus0.b[k*OUT_W +: OUT_W]), exp);
    end
  endtask

  task automatic check_b1(input string tag);
    logic [31:0] exp;
    for (int k = 0; k < 9; k++) begin
      exp = exp_q.pop_front();
      chk($sformatf("%s_b%0d", tag, k), sx12(bus1.b[k*OUT_W_S +: OUT_W_S]), exp);
    end
  endtask

  // ---------------- driver tasks (dut0) ----------------
  task automatic accept0(input logic [71:0] mat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus0.in_ready !== 1'b1 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    bus0.a        = mat;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    for (int k = 0; k < 9; k++) bus0.a[k*8 +: 8] = 8'($urandom_range(0, 255));
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_out0(output int lat);
    lat = 0;
    while (bus0.out_valid !== 1'b1 && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain0();
    @(negedge clk);
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    chk("drain_out_valid", bus0.out_valid, 0);
    chk("drain_in_ready", bus0.in_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  logic stable;
  logic [143:0] snap_b;
  logic [25:0]  snap_det;

  initial begin
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.a = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_det", sxd(bus0.det), 0);
    chk("rst_singular", bus0.singular, 0);
    chk("rst_b_zero", (bus0.b == '0), 1);
    chk("rst_state", bus0.dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity
    push9(256, 0, 0, 0, 256, 0, 0, 0, 256);
    accept0(pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    chk("ident_in_ready_busy", bus0.in_ready, 0);
    wait_out0(lat);
    chk("ident_latency", lat, LAT_FULL);
    chk("ident_det", sxd(bus0.det), 1);
    chk("ident_singular", bus0.singular, 0);
    check_b0("ident");
    drain0();

    // diag(2,4,-8)
    push9(128, 0, 0, 0, 64, 0, 0, 0, -32);
    accept0(pk(2, 0, 0, 0, 4, 0, 0, 0, -8));
    wait_out0(lat);
    chk("diag_latency", lat, LAT_FULL);
    chk("diag_det", sxd(bus0.det), -64);
    check_b0("diag");
    drain0();

    // diag(-3,1,1): truncation toward zero of a negative quotient
    push9(-85, 0, 0, 0, 256, 0, 0, 0, 256);
    accept0(pk(-3, 0, 0, 0, 1, 0, 0, 0, 1));
    wait_out0(lat);
    chk("trunc_det", sxd(bus0.det), -3);
    check_b0("trunc");
    drain0();

    // Full symmetric matrix [[2,1,0],[1,3,1],[0,1,4]], det 18
    push9(156, -56, 14, -56, 113, -28, 14, -28, 71);
    accept0(pk(2, 1, 0, 1, 3, 1, 0, 1, 4));
    wait_out0(lat);
    chk("full_det", sxd(bus0.det), 18);
    chk("full_singular", bus0.singular, 0);
    check_b0("full");
    drain0();

    // Singular rows [1,2,3],[2,4,6],[1,1,1]
    push9(0, 0, 0, 0, 0, 0, 0, 0, 0);
    accept0(pk(1, 2, 3, 2, 4, 6, 1, 1, 1));
    wait_out0(lat);
    chk("sing_latency", lat, LAT_SING);
    chk("sing_det", sxd(bus0.det), 0);
    chk("sing_flag", bus0.singular, 1);
    check_b0("sing");
    drain0();

    // Saturation on the OUT_W=12 instance
    push9(-2048, 2047, 0, 2047, -2048, 0, 0, 0, 256);
    @(negedge clk);
    bus1.a        = pk(127, 126, 0, 126, 125, 0, 0, 0, 1);
    bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("sat_latency", lat, LAT_FULL);
    chk("sat_det", sxd(bus1.det), -1);
    chk("sat_singular", bus1.singular, 0);
    check_b1("sat");
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    chk("sat_drain_in_ready", bus1.in_ready, 1);

    // Handshake: hold out_ready low for 20 cycles with a competing in_valid
    push9(128, 0, 0, 0, 64, 0, 0, 0, -32);
    accept0(pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    wait_out0(lat);
    snap_b   = bus0.b;
    snap_det = bus0.det;
    stable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus0.a        = pk(2, 0, 0, 0, 4, 0, 0, 0, -8);
      bus0.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (bus0.b !== snap_b || bus0.det !== snap_det || bus0.out_valid !== 1'b1 ||
          bus0.in_ready !== 1'b0 || bus0.singular !== 1'b0)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_det", sxd(bus0.det), 1);
    @(negedge clk);
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    chk("hs_out_valid_drop", bus0.out_valid, 0);
    chk("hs_in_ready_back", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    chk("hs_next_accepted", bus0.in_ready, 0);
    wait_out0(lat);
    chk("hs_next_latency", lat, LAT_FULL);
    chk("hs_next_det", sxd(bus0.det), -64);
    check_b0("hs_next");
    drain0();

    // Reset in the middle of DIV
    accept0(pk(2, 0, 0, 0, 4, 0, 0, 0, -8));
    repeat (100) @(posedge clk);
    #1;
    chk("mid_state_div", bus0.dbg_state, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus0.out_valid, 0);
    chk("mid_rst_in_ready", bus0.in_ready, 1);
    chk("mid_rst_state", bus0.dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus0.out_valid !== 1'b0) stable = 1'b0;
    end
    chk("mid_no_partial", stable, 1);
    push9(256, 0, 0, 0, 256, 0, 0, 0, 256);
    accept0(pk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    wait_out0(lat);
    chk("post_rst_latency", lat, LAT_FULL);
    chk("post_rst_det", sxd(bus0.det), 1);
    check_b0("post_rst");
    drain0();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
